// File: rtl/prog_mod_counter.sv
// Runtime-programmable modulo counter with direction, one-shot/continuous runs and a shadow modulus.
// Latency: q, m_cur, busy and done_tick update the cycle after the causing input; tc_tick and max_tick are combinational.
// Backpressure: none. en qualifies each step, and while en is low the counter (and the prescaler, when built) holds.
//
// Ports:
//   clk, reset          rising-edge clock and synchronous active-high reset
//   en, up              step qualifier and direction (1 = up)
//   start, stop         run control pulses (stop wins when both are high)
//   oneshot             1 = halt after the first terminal step, 0 = wrap forever
//   load_m, m_in        write a new modulus into the shadow register (0 encodes 2^N)
//   q, m_cur            current count and the modulus in effect
//   busy                high while running
//   max_tick            level, q == m_cur-1
//   tc_tick             combinational, a terminal step happens this cycle
//   done_tick           one-cycle pulse after a one-shot run completes
//
// Build option: define PROG_CNT_PRESCALE_EN to insert a mod-PRESC prescaler in front of
// the step logic. Without it PRESC is ignored and no prescaler is built.

module prog_mod_counter #(
    parameter int N     = 4,
    parameter int M     = 10,
    parameter int PRESC = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         start,
    input  logic         stop,
    input  logic         oneshot,
    input  logic         load_m,
    input  logic [N-1:0] m_in,
    output logic [N-1:0] q,
    output logic [N-1:0] m_cur,
    output logic         busy,
    output logic         max_tick,
    output logic         tc_tick,
    output logic         done_tick
);

    localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] M_RST = N'(M);

    // A prescale ratio below 1 is meaningless. This elaborates to an empty
    // block so a bad override is at least visible in the hierarchy.
    if (PRESC < 1) begin : g_presc_invalid
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Shadow modulus: written by load_m, applied in IDLE, on start or on a wrap.
    logic         pend_vld;
    logic [N-1:0] pend_m;

    // A load_m in the same cycle as the apply point takes precedence over the
    // older pending value, so the freshly written modulus is used at once.
    logic         new_avail;
    logic [N-1:0] new_m;
    logic [N-1:0] eff_m;

    logic run_en;
    logic step;
    logic terminal;
    logic wrap;
    logic finish;
    logic restart;
    logic apply_m;

    assign new_avail = load_m | pend_vld;
    assign new_m     = load_m ? m_in : pend_m;
    assign eff_m     = new_avail ? new_m : m_cur;

    assign run_en = (state == RUN) & en;

`ifdef PROG_CNT_PRESCALE_EN
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESC - 1);
    localparam logic [PW-1:0] PSC_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] psc;
    logic          psc_tc;

    assign psc_tc = (psc == PSC_LAST);
    assign step   = run_en & psc_tc;

    // The prescaler only advances on enabled RUN cycles. It restarts its phase
    // on start and stop so every run begins with a full prescale period.
    always_ff @(posedge clk) begin
        if (reset || start || stop) begin
            psc <= '0;
        end else if (run_en) begin
            psc <= psc_tc ? '0 : psc + PSC_ONE;
        end
    end
`else
    assign step = run_en;
`endif

    // Modulus 0 makes m_cur-1 wrap to all-ones, which is the 2^N range.
    assign terminal = up ? (q == m_cur - ONE) : (q == '0);
    assign tc_tick  = step & terminal;
    assign max_tick = (q == m_cur - ONE);

    assign wrap    = tc_tick & ~oneshot;
    assign finish  = tc_tick & oneshot;
    assign restart = start & ~stop;

    // The pending modulus is applied in IDLE at any time, on a restart, and on
    // a wrap. A stop defers the apply to the following IDLE cycle.
    assign apply_m = (state == IDLE) | restart | (wrap & ~stop);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (restart) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RUN;
                end else if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // ---------------------------------------------------------- modulus
    always_ff @(posedge clk) begin
        if (reset) begin
            m_cur    <= M_RST;
            pend_vld <= 1'b0;
            pend_m   <= '0;
        end else if (apply_m && new_avail) begin
            m_cur    <= new_m;
            pend_vld <= 1'b0;
        end else if (load_m) begin
            pend_vld <= 1'b1;
            pend_m   <= m_in;
        end
    end

    // ------------------------------------------------------------ count
    // The priority is stop, then start, then step. A one-shot terminal step
    // leaves q on its terminal value. A wrap reloads q from eff_m, so the
    // reload uses a modulus that is applied in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (stop) begin
            q <= q;
        end else if (start) begin
            q <= up ? '0 : eff_m - ONE;
        end else if (step) begin
            if (terminal) begin
                if (!oneshot) begin
                    q <= up ? '0 : eff_m - ONE;
                end
            end else begin
                q <= up ? q + ONE : q - ONE;
            end
        end
    end

    // done_tick marks a one-shot run that ends by itself. A run that is
    // stopped or restarted on its terminal step does not produce done_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_tick <= 1'b0;
        end else begin
            done_tick <= finish & ~stop & ~start;
        end
    end

endmodule

// File: tb/tb_prog_mod_counter.sv
module tb_prog_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       oneshot = 1'b0;
    logic       load_m = 1'b0;
    logic [3:0] m_in = 4'd0;
    logic [3:0] q;
    logic [3:0] m_cur;
    logic       busy;
    logic       max_tick;
    logic       tc_tick;
    logic       done_tick;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] m;
        logic       busy;
        logic       tc;
        logic       done;
        logic       mx;
    } obs_t;

    prog_mod_counter #(.N(4), .M(10), .PRESC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .start     (start),
        .stop      (stop),
        .oneshot   (oneshot),
        .load_m    (load_m),
        .m_in      (m_in),
        .q         (q),
        .m_cur     (m_cur),
        .busy      (busy),
        .max_tick  (max_tick),
        .tc_tick   (tc_tick),
        .done_tick (done_tick)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(int qv, int mv, bit b, bit t, bit d);
        obs_t       e;
        logic [3:0] mm1;
        e.q    = 4'(qv);
        e.m    = 4'(mv);
        mm1    = e.m - 4'd1;
        e.busy = b;
        e.tc   = t;
        e.done = d;
        e.mx   = (e.q == mm1);
        return e;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("q=%0d m=%0d busy=%b tc=%b done=%b max=%b",
                         o.q, o.m, o.busy, o.tc, o.done, o.mx);
    endfunction

    // One clock cycle. tc_tick is sampled before the edge while this cycle's
    // inputs are stable. The registered outputs are sampled just after the edge.
    task automatic cycle(output obs_t o);
        logic tc_s;
        #1 tc_s = tc_tick;
        @(posedge clk);
        #1;
        o.q    = q;
        o.m    = m_cur;
        o.busy = busy;
        o.tc   = tc_s;
        o.done = done_tick;
        o.mx   = max_tick;
    endtask

    task automatic idle_inputs();
        en = 0; up = 0; start = 0; stop = 0; oneshot = 0; load_m = 0; m_in = 0;
    endtask

    task automatic do_reset();
        obs_t o;
        idle_inputs();
        reset = 1;
        cycle(o);
        cycle(o);
        reset = 0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        obs_t exp_q[$];
        idle_inputs();
        reset = 1;
        cycle(o);
        exp_q.push_back(mk(0, 10, 0, 0, 0));
        cycle(o);
        reset = 0;
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_continuous_up();
        obs_t o, e;
        obs_t exp_q[$];
        do_reset();
        for (int k = 0; k < 25; k++)
            exp_q.push_back(mk(k % 10, 10, 1, (k > 0) && ((k - 1) % 10 == 9), 0));
        en = 1; up = 1; oneshot = 0; start = 1;
        for (int k = 0; k < 25; k++) begin
            cycle(o);
            start = 0;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL cont_up k=%0d got %s exp %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_oneshot_down();
        obs_t o, e;
        obs_t exp_q[$];
        do_reset();
        exp_q.push_back(mk(9, 10, 1, 0, 0));
        for (int k = 1; k <= 9; k++) exp_q.push_back(mk(9 - k, 10, 1, 0, 0));
        exp_q.push_back(mk(0, 10, 0, 1, 1));
        exp_q.push_back(mk(0, 10, 0, 0, 0));
        exp_q.push_back(mk(0, 10, 0, 0, 0));
        en = 1; up = 0; oneshot = 1; start = 1;
        for (int k = 0; k < 13; k++) begin
            cycle(o);
            start = 0;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL oneshot_down k=%0d got %s exp %s", k, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_shadow_modulus();
        obs_t o, e;
        obs_t exp_q[$];
        int   tail[13];
        tail = '{5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 0, 1, 2};
        do_reset();
        for (int k = 0; k <= 4; k++) exp_q.push_back(mk(k, 10, 1, 0, 0));
        for (int i = 0; i < 13; i++)
            exp_q.push_back(mk(tail[i], (i >= 5) ? 5 : 10, 1, tail[i] == 0, 0));
        en = 1; up = 1; oneshot = 0; start = 1;
        for (int k = 0; k < 18; k++) begin
            load_m = (k == 4);
            m_in   = (k == 4) ? 4'd5 : 4'd0;
            cycle(o);
            start = 0;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL shadow_mod k=%0d got %s exp %s", k, fmt(o), fmt(e));
            end
        end
        load_m = 0;
    endtask

    task automatic test_mod_extremes();
        obs_t o, e;
        obs_t exp_q[$];
        do_reset();
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 1, 0, 0));
        for (int k = 2; k <= 19; k++)
            exp_q.push_back(mk((k - 1) % 16, 0, 1, ((k - 1) % 16) == 0, 0));
        exp_q.push_back(mk(2, 0, 0, 0, 0));
        exp_q.push_back(mk(2, 1, 0, 0, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 0));
        for (int k = 23; k <= 25; k++) exp_q.push_back(mk(0, 1, 1, 1, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 0));
        exp_q.push_back(mk(0, 1, 1, 1, 0));
        up = 1; oneshot = 0;
        for (int k = 0; k < 28; k++) begin
            load_m = (k == 0) || (k == 21);
            m_in   = (k == 21) ? 4'd1 : 4'd0;
            start  = (k == 1) || (k == 22);
            stop   = (k == 20);
            en     = !((k == 0) || (k == 20) || (k == 21) || (k == 26));
            cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mod_extremes k=%0d got %s exp %s", k, fmt(o), fmt(e));
            end
        end
        idle_inputs();
    endtask

    task automatic test_start_stop_reset();
        obs_t o, e;
        obs_t exp_q[$];
        do_reset();
        for (int k = 0; k <= 6; k++) exp_q.push_back(mk(k, 10, 1, 0, 0));
        exp_q.push_back(mk(6, 10, 0, 0, 0));
        exp_q.push_back(mk(6, 7, 0, 0, 0));
        exp_q.push_back(mk(6, 7, 0, 0, 0));
        exp_q.push_back(mk(0, 7, 1, 0, 0));
        for (int k = 11; k <= 16; k++) exp_q.push_back(mk(k - 10, 7, 1, 0, 0));
        exp_q.push_back(mk(0, 10, 0, 0, 0));
        up = 1; oneshot = 0;
        for (int k = 0; k < 18; k++) begin
            start  = (k == 0) || (k == 9) || (k == 10);
            stop   = (k == 7) || (k == 9);
            load_m = (k == 7);
            m_in   = (k == 7) ? 4'd7 : 4'd0;
            en     = !((k >= 7 && k <= 9) || (k == 17));
            reset  = (k == 17);
            cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL start_stop_reset k=%0d got %s exp %s", k, fmt(o), fmt(e));
            end
        end
        reset = 0;
        idle_inputs();
    endtask

`ifdef PROG_CNT_PRESCALE_EN
    task automatic test_prescale();
        obs_t o, e;
        obs_t exp_q[$];
        do_reset();
        exp_q.push_back(mk(0, 10, 1, 0, 0));
        for (int k = 1; k <= 8; k++) exp_q.push_back(mk(k / 4, 10, 1, 0, 0));
        exp_q.push_back(mk(2, 10, 1, 0, 0));
        for (int k = 10; k <= 12; k++) exp_q.push_back(mk(2, 10, 1, 0, 0));
        exp_q.push_back(mk(3, 10, 1, 0, 0));
        up = 1; oneshot = 0;
        for (int k = 0; k < 14; k++) begin
            start = (k == 0);
            en    = (k != 9);
            cycle(o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL prescale k=%0d got %s exp %s", k, fmt(o), fmt(e));
            end
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_continuous_up();
        test_oneshot_down();
        test_shadow_modulus();
        test_mod_extremes();
        test_start_stop_reset();
`ifdef PROG_CNT_PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
